uart_tx_scheduler: RTL and testbench

//  Arbitrates two result sources onto the single UART transmitter: the 8-bit register-file

---
 rtl/uart_tx_scheduler.sv | 133 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Two-source byte scheduler for a single UART transmitter: RF bytes and two-byte ALU results,
// round-robin arbitrated, each byte paced on the transmitter busy flag with a hang timeout.
module uart_tx_scheduler #(
  parameter int unsigned TIMEOUT     = 64,
  parameter bit          ALU_MSB_1ST = 1'b0
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  rf_data,
  input  logic        rf_valid,
  output logic        rf_ack,
  input  logic [15:0] alu_data,
  input  logic        alu_valid,
  output logic        alu_ack,
  input  logic        tx_busy,
  output logic [7:0]  tx_p_data,
  output logic        tx_data_valid,
  output logic        sched_busy,
  output logic        frame_done,
  output logic        timeout_err
);

  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, WAIT_HI, WAIT_LO} state_t;
  typedef enum logic {SRC_RF, SRC_ALU} src_t;

  state_t        state_q, state_d;
  src_t          last_q, last_d;
  logic          rem_q, rem_d;
  logic [7:0]    hold_q, hold_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    data_q, data_d;
  logic          valid_d, rf_ack_d, alu_ack_d, done_d, terr_d;
  logic          grant_alu;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q       <= IDLE;
      last_q        <= SRC_ALU;
      rem_q         <= 1'b0;
      hold_q        <= '0;
      cnt_q         <= '0;
      data_q        <= '0;
      tx_data_valid <= 1'b0;
      rf_ack        <= 1'b0;
      alu_ack       <= 1'b0;
      frame_done    <= 1'b0;
      timeout_err   <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      rem_q         <= rem_d;
      hold_q        <= hold_d;
      cnt_q         <= cnt_d;
      data_q        <= data_d;
      tx_data_valid <= valid_d;
      rf_ack        <= rf_ack_d;
      alu_ack       <= alu_ack_d;
      frame_done    <= done_d;
      timeout_err   <= terr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    rem_d     = rem_q;
    hold_d    = hold_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    rf_ack_d  = 1'b0;
    alu_ack_d = 1'b0;
    done_d    = 1'b0;
    terr_d    = 1'b0;
    grant_alu = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!tx_busy && (rf_valid || alu_valid)) begin
          // Contention goes to whichever source was not served last.
          grant_alu = alu_valid && (!rf_valid || (last_q == SRC_RF));
          if (grant_alu) begin
            alu_ack_d = 1'b1;
            data_d    = ALU_MSB_1ST ? alu_data[15:8] : alu_data[7:0];
            hold_d    = ALU_MSB_1ST ? alu_data[7:0]  : alu_data[15:8];
            rem_d     = 1'b1;
            last_d    = SRC_ALU;
          end else begin
            rf_ack_d  = 1'b1;
            data_d    = rf_data;
            rem_d     = 1'b0;
            last_d    = SRC_RF;
          end
          valid_d = 1'b1;
          cnt_d   = '0;
          state_d = WAIT_HI;
        end
      end
      WAIT_HI: begin
        if (tx_busy) begin
          state_d = WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          terr_d  = 1'b1;
          rem_d   = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      WAIT_LO: begin
        if (!tx_busy) begin
          if (rem_q) begin
            data_d  = hold_q;
            valid_d = 1'b1;
            rem_d   = 1'b0;
            cnt_d   = '0;
            state_d = WAIT_HI;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_p_data  = data_q;
  assign sched_busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed and randomized bench for uart_tx_scheduler with a behavioural UART busy model and
// a transaction-level arbitration/byte-order reference.
module tb_uart_tx_scheduler;
  localparam int unsigned TIMEOUT = 8;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic [7:0]  rf_data = '0;
  logic        rf_valid = 1'b0;
  logic        rf_ack;
  logic [15:0] alu_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ack;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_p_data;
  logic        tx_data_valid;
  logic        sched_busy;
  logic        frame_done;
  logic        timeout_err;

  uart_tx_scheduler #(.TIMEOUT(TIMEOUT), .ALU_MSB_1ST(1'b0)) dut (
    .CLK(CLK), .RST(RST),
    .rf_data(rf_data), .rf_valid(rf_valid), .rf_ack(rf_ack),
    .alu_data(alu_data), .alu_valid(alu_valid), .alu_ack(alu_ack),
    .tx_busy(tx_busy), .tx_p_data(tx_p_data), .tx_data_valid(tx_data_valid),
    .sched_busy(sched_busy), .frame_done(frame_done), .timeout_err(timeout_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int rise_at = 0, fall_at = 0, last_fall_cyc = 0;
  int dly_min = 1, dly_max = 3, len_min = 1, len_max = 8;
  bit hang = 1'b0;
  bit prev_busy = 1'b0, prev_sched = 1'b0;
  int done_cnt = 0, terr_cnt = 0, rf_ack_cnt = 0, alu_ack_cnt = 0;
  logic [7:0] tx_log[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic timed_out(input string tag);
    checks++;
    errors++;
    $error("FAIL %s: observed no event expected event within bound", tag);
  endtask

  // One clock: sample at the falling edge, log, then drive the UART busy model.
  task automatic step();
    bit nb;
    @(negedge CLK);
    cyc++;
    if (tx_data_valid) begin
      chk("issue_while_busy", {31'd0, prev_busy}, 32'd0);
      tx_log.push_back(tx_p_data);
      if (!hang) begin
        rise_at = cyc + int'($urandom_range(dly_max, dly_min));
        fall_at = rise_at + int'($urandom_range(len_max, len_min));
      end
    end
    if (frame_done)  done_cnt++;
    if (timeout_err) terr_cnt++;
    if (rf_ack)      rf_ack_cnt++;
    if (alu_ack)     alu_ack_cnt++;
    if (rf_ack || alu_ack) chk("grant_overlap", {31'd0, prev_sched}, 32'd0);
    prev_sched = sched_busy;
    nb = (cyc >= rise_at) && (cyc < fall_at);
    if (tx_busy && !nb) last_fall_cyc = cyc;
    tx_busy   = nb;
    prev_busy = nb;
  endtask

  function automatic bit sig(input int sel);
    case (sel)
      0: return frame_done;
      1: return timeout_err;
      4: return tx_data_valid;
      5: return rf_ack || alu_ack;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int limit, input string tag, output int at);
    at = -1;
    for (int i = 0; i < limit; i++) begin
      step();
      if (sig(sel)) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) timed_out(tag);
  endtask

  initial begin
    #200us;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1);
  end

  initial begin
    int at, g, base, d0, a0, r0, grants, last_src, exp_src;
    bit v_rf_prev, v_alu_prev, rf_cool, alu_cool;
    logic [7:0] exp_q[$];
    logic [15:0] w;

    // Reset state
    step(); step();
    chk("rst_rf_ack", {31'd0, rf_ack}, 0);
    chk("rst_alu_ack", {31'd0, alu_ack}, 0);
    chk("rst_tx_p_data", {24'd0, tx_p_data}, 0);
    chk("rst_tx_valid", {31'd0, tx_data_valid}, 0);
    chk("rst_sched_busy", {31'd0, sched_busy}, 0);
    chk("rst_frame_done", {31'd0, frame_done}, 0);
    chk("rst_timeout_err", {31'd0, timeout_err}, 0);
    RST = 1'b1;
    step();

    // Single RF byte, busy rises 2 cycles after issue and lasts 20
    dly_min = 2; dly_max = 2; len_min = 20; len_max = 20;
    rf_data = 8'hA5; rf_valid = 1'b1;
    step();
    chk("t1_rf_ack", {31'd0, rf_ack}, 1);
    chk("t1_tx_valid", {31'd0, tx_data_valid}, 1);
    chk("t1_tx_p_data", {24'd0, tx_p_data}, 32'hA5);
    rf_valid = 1'b0;
    wait_sig(0, 60, "t1_frame_done", at);
    chk("t1_done_after_fall", at, last_fall_cyc + 1);
    chk("t1_hold_data", {24'd0, tx_p_data}, 32'hA5);

    // ALU frame, LSB first
    dly_min = 1; dly_max = 3; len_min = 3; len_max = 10;
    d0 = done_cnt; a0 = alu_ack_cnt;
    alu_data = 16'h1234; alu_valid = 1'b1;
    step();
    chk("t2_alu_ack", {31'd0, alu_ack}, 1);
    chk("t2_byte0", {24'd0, tx_p_data}, 32'h34);
    alu_valid = 1'b0;
    wait_sig(4, 40, "t2_second_valid", at);
    chk("t2_second_after_fall", at, last_fall_cyc + 1);
    chk("t2_byte1", {24'd0, tx_p_data}, 32'h12);
    wait_sig(0, 40, "t2_frame_done", at);
    chk("t2_done_after_fall", at, last_fall_cyc + 1);
    chk("t2_one_ack", alu_ack_cnt - a0, 1);
    chk("t2_one_done", done_cnt - d0, 1);

    // Both requesters held from reset: strict alternation starting with RF
    RST = 1'b0;
    step();
    rf_data = 8'h5A; alu_data = 16'hA55A;
    rf_valid = 1'b1; alu_valid = 1'b1;
    RST = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_sig(5, 80, "t3_grant", at);
      chk("t3_rf_order", {31'd0, rf_ack}, (k % 2 == 0) ? 1 : 0);
      chk("t3_alu_order", {31'd0, alu_ack}, (k % 2 == 1) ? 1 : 0);
      chk("t3_byte", {24'd0, tx_p_data}, (k % 2 == 0) ? {24'd0, rf_data} : {24'd0, alu_data[7:0]});
      if (rf_ack) rf_valid = 1'b0;
      if (alu_ack) alu_valid = 1'b0;
      step();
      if (k < 2) begin
        if (!rf_valid) begin rf_data = 8'($urandom); rf_valid = 1'b1; end
        if (!alu_valid) begin alu_data = 16'($urandom); alu_valid = 1'b1; end
      end
    end
    rf_valid = 1'b0; alu_valid = 1'b0;
    wait_sig(0, 80, "t3_drain", at);

    // Transmitter never goes busy: abandon after TIMEOUT WAIT_HI cycles
    hang = 1'b1;
    d0 = done_cnt;
    alu_data = 16'hBEEF; alu_valid = 1'b1;
    step();
    chk("t4_alu_ack", {31'd0, alu_ack}, 1);
    chk("t4_byte0", {24'd0, tx_p_data}, 32'hEF);
    g = cyc;
    alu_valid = 1'b0;
    base = tx_log.size();
    wait_sig(1, 20, "t4_timeout", at);
    chk("t4_timeout_cycle", at, g + int'(TIMEOUT));
    step();
    chk("t4_sched_idle", {31'd0, sched_busy}, 0);
    chk("t4_pulse_width", {31'd0, timeout_err}, 0);
    repeat (5) step();
    chk("t4_second_dropped", tx_log.size(), base);
    chk("t4_no_done", done_cnt, d0);
    hang = 1'b0;

    // Reset during the second-byte WAIT_LO of an ALU frame
    dly_min = 1; dly_max = 1; len_min = 6; len_max = 6;
    alu_data = 16'hC0DE; alu_valid = 1'b1;
    step();
    alu_valid = 1'b0;
    wait_sig(4, 40, "t5_second_valid", at);
    chk("t5_byte1", {24'd0, tx_p_data}, 32'hC0);
    repeat (3) step();
    chk("t5_in_frame", {31'd0, sched_busy}, 1);
    d0 = done_cnt;
    #2 RST = 1'b0;
    #1;
    chk("t5_async_outputs", {rf_ack, alu_ack, tx_data_valid, sched_busy, frame_done, timeout_err, tx_p_data}, 0);
    rise_at = 0; fall_at = 0; tx_busy = 1'b0; prev_busy = 1'b0;
    rf_data = 8'h77; alu_data = 16'h8899;
    rf_valid = 1'b1; alu_valid = 1'b1;
    step(); step();
    RST = 1'b1;
    step();
    chk("t5_rf_first", {30'd0, rf_ack, alu_ack}, 32'b10);
    chk("t5_rf_byte", {24'd0, tx_p_data}, 32'h77);
    rf_valid = 1'b0; alu_valid = 1'b0;
    wait_sig(0, 40, "t5_drain", at);
    chk("t5_lost_frame", done_cnt - d0, 1);

    // Randomized traffic against a transaction-level arbitration/byte-order model
    dly_min = 1; dly_max = 3; len_min = 1; len_max = 8;
    last_src = 0;
    grants = 0; d0 = done_cnt;
    rf_cool = 1'b0; alu_cool = 1'b0;
    tx_log.delete();
    for (int i = 0; i < 3000 && grants < 40; i++) begin
      if (rf_cool) rf_cool = 1'b0;
      else if (!rf_valid && $urandom_range(3) == 0) begin rf_data = 8'($urandom); rf_valid = 1'b1; end
      if (alu_cool) alu_cool = 1'b0;
      else if (!alu_valid && $urandom_range(3) == 0) begin alu_data = 16'($urandom); alu_valid = 1'b1; end
      v_rf_prev = rf_valid; v_alu_prev = alu_valid;
      step();
      if (rf_ack || alu_ack) begin
        if (v_rf_prev && v_alu_prev) exp_src = 1 - last_src;
        else exp_src = v_alu_prev ? 1 : 0;
        chk("rnd_grant_src", {30'd0, alu_ack, rf_ack}, (exp_src == 1) ? 32'b10 : 32'b01);
        chk("rnd_issue_with_ack", {31'd0, tx_data_valid}, 1);
        last_src = exp_src;
        if (exp_src == 1) begin
          w = alu_data;
          exp_q.push_back(w[7:0]);
          exp_q.push_back(w[15:8]);
        end else begin
          exp_q.push_back(rf_data);
        end
        if (rf_ack) begin rf_valid = 1'b0; rf_cool = 1'b1; end
        if (alu_ack) begin alu_valid = 1'b0; alu_cool = 1'b1; end
        grants++;
      end
    end
    rf_valid = 1'b0; alu_valid = 1'b0;
    repeat (60) step();
    chk("rnd_grant_count", grants, 40);
    chk("rnd_done_count", done_cnt - d0, grants);
    chk("rnd_byte_count", tx_log.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < tx_log.size(); i++)
      chk("rnd_byte", {24'd0, tx_log[i]}, {24'd0, exp_q[i]});
    chk("rnd_no_timeout", terr_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
